sync_fifo_flags: RTL

//  Parametrised single-clock FIFO: first-word-fall-through read, same-cycle empty bypass,

---
 rtl/sync_fifo_flags.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
//   Parametrised single-clock FIFO with first-word-fall-through read data,
//   same-cycle bypass when empty, fill count, almost-full/almost-empty
//   thresholds and sticky overflow/underflow error flags.
//
// Optional build macro:
//   FIFO_WATERMARK_EN - adds the peak_count output (highest fill level seen
//                       since rst or clr_err). Undefined: port and logic absent.
//
// Ports
//   clk           in   1         clock, all state on rising edge
//   rst           in   1         synchronous, active-high reset
//   wr_en         in   1         write request
//   wr_data       in   WIDTH     write data
//   rd_en         in   1         read request (pops rd_data)
//   rd_data       out  WIDTH     head-of-FIFO data, combinational
//   full          out  1         count == DEPTH
//   empty         out  1         count == 0
//   almost_full   out  1         count >= AFULL_TH
//   almost_empty  out  1         count <= AEMPTY_TH
//   count         out  ADDR_W+1  entries stored, 0..DEPTH
//   overflow      out  1         sticky: a write was dropped
//   underflow     out  1         sticky: read from empty with nothing bypassed
//   clr_err       in   1         clears overflow/underflow at the next edge
//   peak_count    out  ADDR_W+1  (FIFO_WATERMARK_EN only) max count reached
//
// Handshake: wr_en and rd_en are request strobes with no back-pressure
// output. A write is accepted when the FIFO is not full, or when it is full
// and a read happens in the same cycle. A read pops the head when the FIFO
// is not empty; when empty, a simultaneous write is passed straight through
// to rd_data (bypass) and never lands in memory. Requests that cannot be
// honoured are dropped and recorded in the sticky error flags.
// -----------------------------------------------------------------------------
module sync_fifo_flags #(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
`ifdef FIFO_WATERMARK_EN
  ,
  output logic [ADDR_W:0]   peak_count
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W:0] AFULL_LV  = (ADDR_W + 1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_LV = (ADDR_W + 1)'(AEMPTY_TH);

  // ---------------------------------------------------------------------------
  // Storage and pointers. Pointers carry one extra wrap bit so that full and
  // empty are distinguishable when the low address bits coincide.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr_nxt;
  logic [ADDR_W:0]   wptr_nxt;

  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W-1:0] waddr;

  logic              bypass;
  logic              rd_ok;
  logic              wr_ok;
  logic              ovf_set;
  logic              unf_set;

  assign raddr = rptr[ADDR_W-1:0];
  assign waddr = wptr[ADDR_W-1:0];

  // ---------------------------------------------------------------------------
  // Status derived purely from the registered pointers.
  // ---------------------------------------------------------------------------
  assign empty        = (rptr == wptr);
  assign full         = (raddr == waddr) && (rptr[ADDR_W] != wptr[ADDR_W]);
  assign count        = wptr - rptr;
  assign almost_full  = (count >= AFULL_LV);
  assign almost_empty = (count <= AEMPTY_LV);

  // ---------------------------------------------------------------------------
  // Request qualification. Nothing is accepted or flagged while rst is high.
  // When full, a simultaneous read frees the slot being written: the write
  // address equals the read address, and the old head is consumed this cycle
  // from the combinational read port before the edge overwrites it.
  // ---------------------------------------------------------------------------
  always_comb begin
    bypass  = 1'b0;
    rd_ok   = 1'b0;
    wr_ok   = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!rst) begin
      bypass  = empty & rd_en & wr_en;
      rd_ok   = rd_en & ~empty;
      wr_ok   = wr_en & ~bypass & (~full | rd_en);
      ovf_set = wr_en & full & ~rd_en;
      unf_set = rd_en & empty & ~wr_en;
    end
  end

  always_comb begin
    rptr_nxt = rptr;
    wptr_nxt = wptr;
    if (rst) begin
      rptr_nxt = '0;
      wptr_nxt = '0;
    end else begin
      if (rd_ok) rptr_nxt = rptr + 1'b1;
      if (wr_ok) wptr_nxt = wptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    rptr <= rptr_nxt;
    wptr <= wptr_nxt;
  end

  // Memory contents are never reset; the pointers make stale words invisible.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[waddr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data: head of FIFO, bypassed write data when empty, otherwise zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    if (!rst) begin
      if (!empty) begin
        rd_data = mem[raddr];
      end else if (bypass) begin
        rd_data = wr_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags. A new error event wins over clr_err in the same cycle
  // so that no event is ever lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (unf_set) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

`ifdef FIFO_WATERMARK_EN
  // ---------------------------------------------------------------------------
  // High-water mark. Tracks the post-edge count so the mark never lags the
  // fill level. clr_err restarts tracking from the count that results from
  // this cycle, so a level reached in the clearing cycle is not lost.
  // ---------------------------------------------------------------------------
  logic [ADDR_W:0] count_nxt;

  assign count_nxt = wptr_nxt - rptr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_count <= '0;
    end else if (clr_err) begin
      peak_count <= count_nxt;
    end else if (count_nxt > peak_count) begin
      peak_count <= count_nxt;
    end
  end
`endif

endmodule
